mem_store_monitor: RTL
======================

# mem_store_monitor

Synthesizable monitor sitting directly downstream of the pipelined processor's memory stage, consuming the same `MemWriteM` / `DataAdrM` / `WriteDataM` store stream that the data memory sees. It records every store in a small FIFO log and counts stores and cycles. It also resolves the run into a sticky PASS / FAIL / TIMEOUT verdict, so benches and FPGA builds get a pass/fail result without waveform inspection.

## Interface
Parameters:
- `PASS_ADDR`, 32'd100: store address that ends the program.
- `PASS_DATA`, 32'd7: data value at `PASS_ADDR` that means success.
- `TIMEOUT_CYCLES`, 90: cycles in RUN before TIMEOUT; must be ≥ 2.
- `LOG_DEPTH`, 8: store log entries; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `MemWriteM`, in, 1: store strobe from the memory stage.
- `DataAdrM`, in, 32: store address.
- `WriteDataM`, in, 32: store data.
- `log_pop`, in, 1: consumer accepts the head log entry.
- `log_valid`, out, 1: head log entry present.
- `log_addr`, out, 32: head entry address.
- `log_data`, out, 32: head entry data.
- `log_overflow`, out, 1: sticky; a store was dropped because the log was full.
- `store_count`, out, 16: stores seen in RUN; saturates at 16'hFFFF.
- `cycle_count`, out, 16: cycles spent in RUN.
- `pass`, `fail`, `timeout`, out, 1 each: one-hot sticky verdict.
- `done`, out, 1: `pass | fail | timeout`.

## Operation
- States are IDLE, RUN, PASS, FAIL and TOUT.
- Reset asserted: state goes to IDLE; all counters, FIFO pointers, `log_overflow` and verdict outputs go to 0; `log_valid` = 0.
- IDLE → RUN on the first clock edge after reset deasserts. No store is sampled in IDLE.
- In RUN, each edge with `MemWriteM` = 1 is a store:
  - `DataAdrM == PASS_ADDR` and `WriteDataM == PASS_DATA` → PASS.
  - `DataAdrM == PASS_ADDR` with any other data → FAIL.
  - The store that causes the transition is itself logged and counted.
- In RUN with `cycle_count == TIMEOUT_CYCLES-1` and no terminating store → TOUT.
- Same edge has a terminating store and the timeout condition: the store verdict wins.
- PASS, FAIL and TOUT are terminal until reset. Stores in these states are ignored: not logged, not counted. `cycle_count` freezes.
- Log push happens on every RUN store.
  - If full and `log_pop` is not asserted, the store is dropped, `log_overflow` is set, and `store_count` still increments.
  - If full and `log_pop` is asserted on the same edge, the push and pop both succeed and the count is unchanged.
- Log pop: an entry is removed on an edge with `log_pop && log_valid`. `log_pop` with an empty log is ignored.
- The log can still be drained after a verdict.
- Counters use unsigned arithmetic. `store_count` saturates at 16'hFFFF. `cycle_count` stops at `TIMEOUT_CYCLES-1`, so the parameter must be ≤ 65536.
- Reset asserted mid-run clears everything asynchronously, including log contents, which are treated as invalid.

## Timing
- All outputs are registered, or driven directly from registered FIFO storage.
- Verdict latency is 1 cycle: `pass`/`fail` is visible after the edge that samples the terminating store.
- `timeout` rises after the edge where `cycle_count` = `TIMEOUT_CYCLES-1`. That is `TIMEOUT_CYCLES` edges after entering RUN.
- `cycle_count` is 0 on RUN entry and increments on every RUN edge.
- The log is show-ahead: after a push into an empty log, `log_valid`, `log_addr` and `log_data` are valid after that same edge. Latency is 1 cycle, with no extra read cycle.
- `log_addr`/`log_data` hold steady while `log_valid` = 1 and `log_pop` = 0.

## Structure
- Shared package `pipeline_mon_pkg` holds:
  - the state enum (IDLE, RUN, PASS, FAIL, TOUT);
  - the store record typedef {addr[31:0], data[31:0]};
  - the default `PASS_ADDR` / `PASS_DATA` constants.
- Sub-module `store_log_fifo` (parameters: depth and a 64-bit record):
  - pointers are log2(`LOG_DEPTH`)+1 bits wide; the MSB distinguishes full from empty;
  - has push, pop, valid, full and head outputs.
- The top level holds the FSM, the counters and the overflow flag.

## Test plan
- Reset held low for 2 cycles, then released:
  - every output is 0 during reset;
  - `cycle_count` = 0 on the first RUN cycle.
- Stores (80,0), (84,5), then (100,7) in RUN:
  - `pass` = 1 and `done` = 1 one cycle later;
  - `store_count` = 3;
  - log pops return (80,0), (84,5), (100,7) in order, then `log_valid` = 0.
- Store (100,3):
  - `fail` = 1 and `pass` = 0;
  - a later store (100,7) changes neither the verdict nor `store_count`.
- No stores for 90 RUN cycles:
  - `timeout` = 1 exactly 90 edges after RUN entry;
  - `cycle_count` holds at 89.
- Store (100,7) on the same edge as `cycle_count` = 89: `pass` = 1 and `timeout` = 0.
- 10 stores with `LOG_DEPTH` = 8 and no pops:
  - `log_overflow` = 1;
  - `store_count` = 10;
  - 8 entries are retrievable, and they are the first 8 stores.
- Store into a full log while `log_pop` = 1: `log_overflow` stays 0.
- Reset asserted mid-log: `log_valid` drops immediately (asynchronously).

Source files
------------

// File: rtl/pipeline_mon_pkg.sv
// Shared types for the memory-stage store monitor: FSM states, the store
// record, and the default pass address/data.
package pipeline_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TOUT
  } mon_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_rec_t;

  localparam logic [31:0] DEF_PASS_ADDR = 32'd100;
  localparam logic [31:0] DEF_PASS_DATA = 32'd7;

endpackage

// File: rtl/store_log_fifo.sv
// Show-ahead FIFO of store records. Pointers carry one extra wrap bit so that
// full and empty can be told apart. valid/full are registered.
module store_log_fifo
  import pipeline_mon_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = store_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rec_t din_i,
  input  logic pop_i,
  output logic valid_o,
  output logic full_o,
  output rec_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  rec_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          valid_q, full_q;
  logic          do_push, do_pop;

  // A push into a full log still succeeds when the head leaves on the same edge.
  assign do_pop  = pop_i && valid_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= (wr_d != rd_d);
      full_q  <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/mem_store_monitor.sv
// Watches the memory-stage store stream: logs stores, counts stores/cycles,
// and latches a sticky PASS / FAIL / TIMEOUT verdict.
module mem_store_monitor
  import pipeline_mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter int          TIMEOUT_CYCLES = 90,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  input  logic        log_pop,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic [15:0] store_count,
  output logic [15:0] cycle_count,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        done
);

  localparam logic [15:0] CC_LAST = 16'(TIMEOUT_CYCLES - 1);

  mon_state_e  state_q;
  logic [15:0] store_q, cycle_q;
  logic        ovf_q, pass_q, fail_q, tout_q, done_q;
  logic        run_store, hit, log_full;
  store_rec_t  din, head;

  assign run_store = (state_q == ST_RUN) && MemWriteM;
  assign hit       = run_store && (DataAdrM == PASS_ADDR);
  assign din       = '{addr: DataAdrM, data: WriteDataM};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      store_q <= '0;
      cycle_q <= '0;
      ovf_q   <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        ST_RUN: begin
          if (run_store && store_q != 16'hFFFF) store_q <= store_q + 16'd1;
          if (cycle_q != CC_LAST) cycle_q <= cycle_q + 16'd1;
          if (run_store && log_full && !log_pop) ovf_q <= 1'b1;
          // A terminating store outranks a timeout on the same edge.
          if (hit) begin
            done_q <= 1'b1;
            if (WriteDataM == PASS_DATA) begin
              state_q <= ST_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end
          end else if (cycle_q == CC_LAST) begin
            state_q <= ST_TOUT;
            tout_q  <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  store_log_fifo #(
    .DEPTH(LOG_DEPTH),
    .rec_t(store_rec_t)
  ) u_log (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (run_store),
    .din_i  (din),
    .pop_i  (log_pop),
    .valid_o(log_valid),
    .full_o (log_full),
    .head_o (head)
  );

  assign log_addr     = head.addr;
  assign log_data     = head.data;
  assign log_overflow = ovf_q;
  assign store_count  = store_q;
  assign cycle_count  = cycle_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = tout_q;
  assign done         = done_q;

endmodule
